// File: rtl/tank_ctrl.sv
// tank_ctrl: per-player heading-based tank movement, fire cooldown and hit/respawn FSM.
// Define TANK_WRAP_EN to wrap positions at the playfield bounds instead of clamping.
module tank_ctrl #(
  parameter logic [7:0] KEY_ROT_L = 8'h04,
  parameter logic [7:0] KEY_ROT_R = 8'h07,
  parameter logic [7:0] KEY_BACK = 8'h16,
  parameter logic [7:0] KEY_FWD = 8'h1A,
  parameter logic [7:0] KEY_FIRE = 8'h2C,
  parameter int X_CENTER = 320,
  parameter int Y_CENTER = 240,
  parameter int X_MIN = 0,
  parameter int X_MAX = 639,
  parameter int Y_MIN = 0,
  parameter int Y_MAX = 479,
  parameter int SIZE = 10,
  parameter int FRAC_BITS = 6,
  parameter int ROT_DIV = 4,
  parameter int FIRE_COOLDOWN = 30,
  parameter int DEAD_FRAMES = 60
) (
  input logic frame_clk,
  input logic Reset_n,
  input logic hit,
  input logic [31:0] keycode,
  input logic [7:0] sin,
  input logic [7:0] cos,
  output logic [9:0] TankX,
  output logic [9:0] TankY,
  output logic [9:0] TankS,
  output logic [9:0] TankXStep,
  output logic [9:0] TankYStep,
  output logic ShootBullet,
  output logic [5:0] Angle,
  output logic Alive
);
  localparam int P = 12 + FRAC_BITS;
  localparam int AW = 10 + FRAC_BITS;
  localparam int DW = $clog2(DEAD_FRAMES + 1);
  localparam int CW = $clog2(FIRE_COOLDOWN + 1);
  localparam int RW = $clog2(ROT_DIV + 1);
  typedef enum logic [1:0] {ALIVE, DEAD, RESPAWN} state_t;
  function automatic logic pressed(input logic [31:0] kc, input logic [7:0] k);
    return kc[7:0] == k || kc[15:8] == k || kc[23:16] == k || kc[31:24] == k;
  endfunction
  // Returns {step, integer part, fraction}; two guard bits catch under/overflow.
  function automatic logic [AW+9:0] axis(input logic [9:0] oi, input logic [FRAC_BITS-1:0] of,
                                         input logic signed [P-1:0] d, input int lo, input int hi);
    logic signed [P-1:0] s, r, l, h;
    logic [9:0] ni;
    logic [FRAC_BITS-1:0] nf;
    s = $signed({2'b00, oi, of}) + d;
    r = s >>> FRAC_BITS;
    l = P'(lo);
    h = P'(hi);
`ifdef TANK_WRAP_EN
    ni = r < l ? h[9:0] : r > h ? l[9:0] : r[9:0];
    nf = s[FRAC_BITS-1:0];
    return {r[9:0] - oi, ni, nf};
`else
    ni = r < l ? l[9:0] : r > h ? h[9:0] : r[9:0];
    nf = (r < l || r > h) ? '0 : s[FRAC_BITS-1:0];
    return {ni - oi, ni, nf};
`endif
  endfunction
  state_t st, st_n;
  logic [DW-1:0] dc, dc_n;
  logic [CW-1:0] cd, cd_n;
  logic [RW-1:0] rc, rc_n;
  logic [FRAC_BITS-1:0] xf, yf, xf_n, yf_n;
  logic [9:0] xi_n, yi_n, xs_n, ys_n;
  logic [5:0] ang_n;
  logic sh_n, rl, rr, bk, fw, fi, one;
  logic signed [P-1:0] cx, cy, dx, dy;
  logic [AW+9:0] ux, uy;
  assign rl = pressed(keycode, KEY_ROT_L);
  assign rr = pressed(keycode, KEY_ROT_R);
  assign bk = pressed(keycode, KEY_BACK);
  assign fw = pressed(keycode, KEY_FWD);
  assign fi = pressed(keycode, KEY_FIRE);
  assign one = rl ^ rr;
  assign cx = {{(P-8){cos[7]}}, cos};
  assign cy = {{(P-8){sin[7]}}, sin};
  assign dx = fw & ~bk ? cx : bk & ~fw ? -cx : '0;
  assign dy = fw & ~bk ? cy : bk & ~fw ? -cy : '0;
  assign ux = axis(TankX, xf, dx, X_MIN + SIZE, X_MAX - SIZE);
  assign uy = axis(TankY, yf, dy, Y_MIN + SIZE, Y_MAX - SIZE);
  assign TankS = 10'(SIZE);
  assign Alive = st == ALIVE;
  always_comb begin
    st_n = st;
    dc_n = dc;
    cd_n = cd != '0 ? cd - 1'b1 : '0;
    rc_n = '0;
    ang_n = Angle;
    xi_n = TankX;
    xf_n = xf;
    yi_n = TankY;
    yf_n = yf;
    xs_n = '0;
    ys_n = '0;
    sh_n = 1'b0;
    case (st)
      ALIVE: begin
        if (hit) begin
          st_n = DEAD;
          dc_n = DW'(DEAD_FRAMES - 1);
        end else begin
          {xs_n, xi_n, xf_n} = ux;
          {ys_n, yi_n, yf_n} = uy;
          rc_n = !one || rc == RW'(ROT_DIV - 1) ? '0 : rc + 1'b1;
          ang_n = one && rc == '0 ? Angle + (rr ? 6'd1 : 6'd63) : Angle;
          if (fi && cd == '0) begin
            sh_n = 1'b1;
            cd_n = CW'(FIRE_COOLDOWN - 1);
          end
        end
      end
      DEAD: begin
        st_n = dc == '0 ? RESPAWN : DEAD;
        dc_n = dc == '0 ? dc : dc - 1'b1;
      end
      RESPAWN: begin
        st_n = ALIVE;
        xi_n = 10'(X_CENTER);
        yi_n = 10'(Y_CENTER);
        xf_n = '0;
        yf_n = '0;
        ang_n = '0;
        cd_n = '0;
      end
      default: st_n = ALIVE;
    endcase
  end
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      st <= ALIVE;
      dc <= '0;
      cd <= '0;
      rc <= '0;
      TankX <= 10'(X_CENTER);
      TankY <= 10'(Y_CENTER);
      xf <= '0;
      yf <= '0;
      TankXStep <= '0;
      TankYStep <= '0;
      ShootBullet <= 1'b0;
      Angle <= '0;
    end else begin
      st <= st_n;
      dc <= dc_n;
      cd <= cd_n;
      rc <= rc_n;
      TankX <= xi_n;
      TankY <= yi_n;
      xf <= xf_n;
      yf <= yf_n;
      TankXStep <= xs_n;
      TankYStep <= ys_n;
      ShootBullet <= sh_n;
      Angle <= ang_n;
    end
  end
endmodule

// File: tb/tb_tank_ctrl.sv
// tb_tank_ctrl: randomized scoreboard bench for tank_ctrl against a sub-pixel arithmetic reference model.
module tb_tank_ctrl;
  localparam int ROT_DIV = 4, FIRE_COOLDOWN = 30, DEAD_FRAMES = 60;
  localparam int XLO = 10, XHI = 629, YLO = 10, YHI = 469;
  logic frame_clk = 1'b0, Reset_n = 1'b0, hit = 1'b0;
  logic [31:0] keycode = '0;
  logic [7:0] sin = '0, cos = '0;
  logic [9:0] TankX, TankY, TankS, TankXStep, TankYStep;
  logic ShootBullet, Alive;
  logic [5:0] Angle;
  tank_ctrl dut (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .hit(hit), .keycode(keycode), .sin(sin), .cos(cos),
    .TankX(TankX), .TankY(TankY), .TankS(TankS), .TankXStep(TankXStep), .TankYStep(TankYStep),
    .ShootBullet(ShootBullet), .Angle(Angle), .Alive(Alive)
  );
  always #5 frame_clk = ~frame_clk;
  typedef struct {int x, y, xs, ys, ang, shoot, alive;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  bit m_dead;
  int m_hit_edge, m_ang, m_px, m_py, m_hold, m_last_fire, m_edge = 0;
  logic [7:0] pool[8] = '{8'h04, 8'h07, 8'h16, 8'h1A, 8'h2C, 8'h00, 8'h00, 8'h55};
  task automatic check(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask
  function automatic bit has(input logic [31:0] kc, input logic [7:0] k);
    for (int i = 0; i < 4; i++) if (kc[8*i+:8] == k) return 1'b1;
    return 1'b0;
  endfunction
  function automatic int trig(input int a, input bit sn);
    real th;
    th = 6.283185307179586 * a / 64.0;
    return sn ? int'(64.0 * $sin(th)) : int'(64.0 * $cos(th));
  endfunction
  function automatic logic [31:0] rkeys();
    logic [31:0] kc;
    for (int b = 0; b < 4; b++) kc[8*b+:8] = pool[$urandom_range(0, 7)];
    return kc;
  endfunction
  // Position is kept in 1/64-pixel units; bounds act on the whole-pixel part.
  task automatic move(inout int p, input int d, input int lo, input int hi, output int stp);
    int o, n;
    o = p / 64;
    p = p + d;
    n = p / 64;
`ifdef TANK_WRAP_EN
    stp = n - o;
    if (n < lo) p = hi * 64 + p % 64;
    else if (n > hi) p = lo * 64 + p % 64;
`else
    if (n < lo) p = lo * 64;
    else if (n > hi) p = hi * 64;
    stp = p / 64 - o;
`endif
  endtask
  task automatic model_reset();
    m_dead = 0;
    m_ang = 0;
    m_px = 320 * 64;
    m_py = 240 * 64;
    m_hold = 0;
    m_last_fire = -100000;
  endtask
  task automatic step_model(input logic [31:0] kc, input bit h, input int c, input int s, output exp_t e);
    bit rl, rr, bk, fw, fi;
    int dir;
    rl = has(kc, 8'h04); rr = has(kc, 8'h07); bk = has(kc, 8'h16);
    fw = has(kc, 8'h1A); fi = has(kc, 8'h2C);
    e.xs = 0; e.ys = 0; e.shoot = 0;
    if (m_dead) begin
      m_hold = 0;
      if (m_edge - m_hit_edge == DEAD_FRAMES + 1) begin
        m_dead = 0;
        m_px = 320 * 64;
        m_py = 240 * 64;
        m_ang = 0;
        m_last_fire = -100000;
      end
    end else if (h) begin
      m_dead = 1;
      m_hit_edge = m_edge;
      m_hold = 0;
    end else begin
      dir = (fw && !bk) ? 1 : (bk && !fw) ? -1 : 0;
      move(m_px, dir * c, XLO, XHI, e.xs);
      move(m_py, dir * s, YLO, YHI, e.ys);
      if (rl != rr) begin
        if (m_hold % ROT_DIV == 0) m_ang = (m_ang + (rr ? 1 : 63)) % 64;
        m_hold++;
      end else m_hold = 0;
      if (fi && m_edge - m_last_fire >= FIRE_COOLDOWN) begin
        e.shoot = 1;
        m_last_fire = m_edge;
      end
    end
    m_edge++;
    e.x = m_px / 64; e.y = m_py / 64; e.ang = m_ang; e.alive = m_dead ? 0 : 1;
  endtask
  task automatic frame(input logic [31:0] kc, input bit h, input bit rst);
    exp_t e;
    int c, s;
    @(negedge frame_clk);
    c = trig(m_ang, 0);
    s = trig(m_ang, 1);
    keycode = kc; hit = h; cos = 8'(c); sin = 8'(s); Reset_n = !rst;
    if (rst) begin
      model_reset();
      e = '{x: 320, y: 240, xs: 0, ys: 0, ang: 0, shoot: 0, alive: 1};
    end else step_model(kc, h, c, s, e);
    q.push_back(e);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge frame_clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("TankX", int'(TankX), e.x);
        check("TankY", int'(TankY), e.y);
        check("TankXStep", int'($signed(TankXStep)), e.xs);
        check("TankYStep", int'($signed(TankYStep)), e.ys);
        check("Angle", int'(Angle), e.ang);
        check("ShootBullet", int'(ShootBullet), e.shoot);
        check("Alive", int'(Alive), e.alive);
        check("TankS", int'(TankS), 10);
      end
    end
  end
  initial begin
    model_reset();
    repeat (2) frame(32'h0, 1'b0, 1'b1);
    repeat (64) frame(32'h0000001A, 1'b0, 1'b0);
    repeat (9) frame(32'h00000007, 1'b0, 1'b0);
    repeat (3) frame(32'h00000704, 1'b0, 1'b0);
    repeat (61) frame(32'h0000002C, 1'b0, 1'b0);
    frame(32'h0, 1'b1, 1'b0);
    repeat (70) frame(rkeys(), $urandom_range(0, 3) == 0, 1'b0);
    frame(32'h0, 1'b0, 1'b1);
    repeat (320) frame(32'h00000016, 1'b0, 1'b0);
    frame(32'h0, 1'b0, 1'b1);
    repeat (61) frame(32'h00000007, 1'b0, 1'b0);
    repeat (240) frame(32'h001A0000, 1'b0, 1'b0);
    for (int p = 0; p < 60; p++) begin
      logic [31:0] kc;
      kc = rkeys();
      repeat ($urandom_range(1, 40)) frame(kc, $urandom_range(0, 99) == 0, $urandom_range(0, 299) == 0);
    end
    frame(32'h0, 1'b1, 1'b0);
    repeat (10) frame(32'h2C1A0716, 1'b0, 1'b0);
    frame(32'h0, 1'b0, 1'b1);
    repeat (5) frame(32'h0000002C, 1'b0, 1'b0);
    repeat (2) @(posedge frame_clk);
    #2;
    check("drain", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tank_ctrl.md
Name: tank_ctrl

Overview:
Parametrised successor of the single-tank movement block. It gives heading-based movement: rotate left/right, drive forward/back along the heading using external sin/cos LUT values, and clamped sub-pixel position. It also adds a fire cooldown and a hit/respawn state machine. One instance per player; the instances sit between the keycode decoder and the sprite/bullet/collision logic and are clocked once per frame.

Parameters:
KEY_ROT_L, 8'h04, keycode that rotates counter-clockwise
KEY_ROT_R, 8'h07, keycode that rotates clockwise
KEY_BACK, 8'h16, keycode that drives backward
KEY_FWD, 8'h1A, keycode that drives forward
KEY_FIRE, 8'h2C, keycode that fires
X_CENTER, 320, spawn X (pixels)
Y_CENTER, 240, spawn Y (pixels)
X_MIN / X_MAX, 0 / 639, playfield X bounds
Y_MIN / Y_MAX, 0 / 479, playfield Y bounds
SIZE, 10, tank half-size; also drives TankS
FRAC_BITS, 6, fractional position bits; sin/cos scale is 1.0 = 2^FRAC_BITS
ROT_DIV, 4, frames per angle step while a rotate key is held (>=1)
FIRE_COOLDOWN, 30, minimum frames between ShootBullet pulses (>=1)
DEAD_FRAMES, 60, frames spent in DEAD after a hit (>=1)

Ports:
frame_clk  in  1  frame-rate clock; every register updates on its rising edge
Reset_n  in  1  asynchronous, active-low reset
hit  in  1  level; tank struck this frame
keycode  in  32  four concurrent 8-bit keycodes; a key counts as pressed if any byte matches
sin  in  8  signed sin(Angle), Q1.FRAC_BITS
cos  in  8  signed cos(Angle), Q1.FRAC_BITS
TankX, TankY  out  10  integer tank centre
TankS  out  10  constant SIZE
TankXStep, TankYStep  out  10  signed integer displacement applied on the last edge
ShootBullet  out  1  one-frame fire pulse
Angle  out  6  heading, 0..63; 0 = +X, increasing is clockwise on screen
Alive  out  1  1 in ALIVE

Behaviour:
- Reset (Reset_n=0, asynchronous): state=ALIVE, TankX=X_CENTER, TankY=Y_CENTER, fraction=0, Angle=0, Step outputs=0, ShootBullet=0, Alive=1, all counters=0.
- Key decode is combinational from keycode and is applied on the same edge. There is no one-frame lag.
- States: ALIVE, DEAD, RESPAWN.
- ALIVE -> DEAD when hit=1 at an edge. Motion, rotation and fire are suppressed on that edge. The death counter loads DEAD_FRAMES-1.
- DEAD: position and Angle hold, Steps=0, ShootBullet=0, Alive=0. hit is ignored. The counter decrements each edge; when the counter is 0, go to RESPAWN.
- RESPAWN (exactly 1 frame): position loads the centre, fraction=0, Angle=0, cooldown=0, Steps=0, Alive=0. hit is ignored. Then go to ALIVE.
- Rotation (ALIVE only):
  - Exactly one rotate key held: Angle steps by ±1 (mod 64, wraps 63<->0) on the first frame of the press, then once every ROT_DIV frames while held.
  - Both rotate keys held, or neither: no step, and the rotate counter clears.
- Movement (ALIVE only), using the sin/cos present at the edge (i.e. for the pre-update Angle):
  - FWD only: X += cos, Y += sin, in (10+FRAC_BITS)-bit fixed point.
  - BACK only: X -= cos, Y -= sin.
  - Both or neither: no movement.
  - Rotation and movement may occur on the same edge.
- Clamp: each axis' integer part is clamped to [MIN+SIZE, MAX-SIZE]. On a clamp the fraction of that axis is zeroed.
- TankXStep/TankYStep = new integer position minus old integer position, registered with the position and sign-extended to 10 bits.
- Fire:
  - In ALIVE with KEY_FIRE held and cooldown==0: ShootBullet=1 for one frame and cooldown loads FIRE_COOLDOWN-1.
  - Otherwise ShootBullet=0 and cooldown decrements while nonzero.
  - Holding fire therefore pulses every FIRE_COOLDOWN frames.
- Reset mid-DEAD or mid-press returns to the reset values immediately.

Optional Feature:
TANK_WRAP_EN: when defined, crossing a bound wraps that axis' integer part to the opposite bound (a position past MAX-SIZE becomes MIN+SIZE, and vice versa) and keeps the fraction. TankXStep/TankYStep then report the motion delta (the sin/cos integer contribution), not the wrap jump. When undefined, positions clamp as specified above.

Test Plan:
1. Reset_n low then high, no keys -> TankX=320, TankY=240, Angle=0, Alive=1, ShootBullet=0, Steps=0.
2. FWD held 64 frames, Angle=0, cos=64, sin=0 -> TankX rises 1/frame to 384, TankYStep=0 throughout.
3. KEY_ROT_R held 9 frames, ROT_DIV=4 -> Angle 1,1,1,1,2,2,2,2,3. Then KEY_ROT_L and KEY_ROT_R both held -> Angle stays 3.
4. KEY_FIRE held 61 frames, FIRE_COOLDOWN=30 -> ShootBullet pulses on frames 0, 30 and 60 only, each 1 frame wide.
5. hit pulse while ALIVE, DEAD_FRAMES=60 -> Alive=0, moves/fire ignored for 60 frames. A second hit during that time is ignored. Then 1 RESPAWN frame at (320,240) with Angle=0, then Alive=1.
6. BACK held, Angle=0, cos=64, start X=15 -> X clamps at 10 and TankXStep=0 after clamp. With TANK_WRAP_EN, X wraps to 629.
